// File: rtl/bcd_sum_display_pkg.sv
// Shared definitions for the BCD sum display: FSM encodings, segment codes
// ({a,b,c,d,e,f,g}, active-high) and digit-enable patterns.
package bcd_sum_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] DIG_OFF  = 2'b00;
  localparam logic [1:0] DIG_ONES = 2'b01;
  localparam logic [1:0] DIG_TENS = 2'b10;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_sum_display_seg7_encoder.sv
// Combinational digit-to-segment encoder. Blank has priority over error,
// error over the digit value. Codes are the inverse of the upstream decoder.
module bcd_sum_display_seg7_encoder
  import bcd_sum_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  input  logic       i_err,
  output logic [6:0] o_seg
);

  // Priority select: blank, then error glyph, then the decimal digit.
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else if (i_err) begin
      o_seg = SEG_E;
    end else begin
      case (i_digit)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_E;
      endcase
    end
  end

endmodule

// File: rtl/bcd_sum_display.sv
// Adds two decoded BCD digits and shows the result on a time-multiplexed
// two-digit 7-segment display.
// Handshake: an operand pair is taken at a rising edge where in_valid and
// in_ready are both high; in_ready depends only on the FSM state (low for
// the single ADD cycle), never on in_valid.
module bcd_sum_display
  import bcd_sum_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  output logic [4:0] sum_bin,
  output logic       sum_valid,
  output logic       err,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic [1:0] dbg_state
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_op_a;
  logic [3:0]       r_op_b;
  logic [4:0]       r_sum_bin;
  logic             r_tens;
  logic [3:0]       r_ones;
  logic             r_err;
  logic             r_sum_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             r_scan_sel;

  logic             w_capture;
  logic [4:0]       w_sum;
  logic             w_tens;
  logic [3:0]       w_ones;
  logic             w_err;
  logic [3:0]       w_enc_digit;
  logic             w_enc_blank;
  logic             w_enc_err;
  logic [6:0]       w_enc_seg;

  assign w_capture = in_valid & in_ready;

  // Adder and BCD split; low nibble arithmetic wraps mod 16, which yields
  // the correct ones digit for every in-range sum (0..18).
  assign w_sum  = {1'b0, r_op_a} + {1'b0, r_op_b};
  assign w_tens = (w_sum >= 5'd10);
  assign w_ones = w_sum[3:0] - (w_tens ? 4'd10 : 4'd0);
  assign w_err  = (r_op_a > BCD_MAX) | (r_op_b > BCD_MAX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: capture always goes to ADD, ADD lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_capture) w_state_nxt = ST_ADD;
      ST_ADD:  w_state_nxt = ST_SHOW;
      ST_SHOW: if (w_capture) w_state_nxt = ST_ADD;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a <= 4'd0;
      r_op_b <= 4'd0;
    end else if (w_capture) begin
      r_op_a <= op_a;
      r_op_b <= op_b;
    end
  end

  // Result registers: loaded at the end of ADD; sum_valid drops while a
  // new pair is being added since nothing is displayed then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_bin   <= 5'd0;
      r_tens      <= 1'b0;
      r_ones      <= 4'd0;
      r_err       <= 1'b0;
      r_sum_valid <= 1'b0;
    end else if (r_state == ST_ADD) begin
      r_sum_bin   <= w_sum;
      r_tens      <= w_tens;
      r_ones      <= w_ones;
      r_err       <= w_err;
      r_sum_valid <= ~w_err;
    end else if (w_capture) begin
      r_sum_valid <= 1'b0;
    end
  end

  // Refresh counter and scan select: cleared during ADD so each new result
  // starts on the ones digit; toggles digit after REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_scan_sel <= 1'b0;
    end else if (r_state != ST_SHOW) begin
      r_cnt      <= '0;
      r_scan_sel <= 1'b0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt      <= '0;
      r_scan_sel <= ~r_scan_sel;
    end else begin
      r_cnt      <= r_cnt + CNT_W'(1);
    end
  end

  // Output decode from state: ready, digit enable and encoder inputs.
  always_comb begin
    in_ready    = (r_state != ST_ADD);
    dig_en      = DIG_OFF;
    w_enc_digit = 4'd0;
    w_enc_blank = 1'b1;
    w_enc_err   = 1'b0;
    if (r_state == ST_SHOW) begin
      if (!r_scan_sel) begin
        dig_en      = DIG_ONES;
        w_enc_digit = r_ones;
        w_enc_blank = 1'b0;
        w_enc_err   = r_err;
      end else begin
        dig_en      = DIG_TENS;
        w_enc_digit = {3'b000, r_tens};
        w_enc_blank = ~r_tens | r_err;
        w_enc_err   = 1'b0;
      end
    end
  end

  bcd_sum_display_seg7_encoder u_enc (
    .i_digit (w_enc_digit),
    .i_blank (w_enc_blank),
    .i_err   (w_enc_err),
    .o_seg   (w_enc_seg)
  );

  assign seg       = w_enc_seg;
  assign sum_bin   = r_sum_bin;
  assign sum_valid = r_sum_valid;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_sum_display.sv
// Directed bench for bcd_sum_display with REFRESH_DIV=4.
module tb_bcd_sum_display;

  localparam int RD = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [4:0] sum_bin;
  logic       sum_valid;
  logic       err;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_sum_display #(.REFRESH_DIV(RD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sum_bin   (sum_bin),
    .sum_valid (sum_valid),
    .err       (err),
    .seg       (seg),
    .dig_en    (dig_en),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture a pair, check the dark ADD cycle, then land in the first SHOW cycle.
  task automatic load(input logic [3:0] a, input logic [3:0] b);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("add_ready", in_ready, 0);
    chk("add_dig",   dig_en, 2'b00);
    chk("add_seg",   seg, 7'b0000000);
    tick();
  endtask

  // Check `periods` half-scans starting from the first SHOW cycle.
  task automatic scan(input string tag, input logic [6:0] ones_seg,
                      input logic [6:0] tens_seg, input int periods);
    for (int p = 0; p < periods; p++) begin
      for (int c = 0; c < RD; c++) begin
        chk({tag, "_dig"}, dig_en, (p % 2 == 0) ? 2'b01 : 2'b10);
        chk({tag, "_seg"}, seg, (p % 2 == 0) ? ones_seg : tens_seg);
        tick();
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    op_a = 4'd0;
    op_b = 4'd0;
    repeat (3) tick();
    chk("rst_ready", in_ready, 1);
    chk("rst_dig",   dig_en, 2'b00);
    chk("rst_seg",   seg, 0);
    chk("rst_sum",   sum_bin, 0);
    chk("rst_valid", sum_valid, 0);
    chk("rst_err",   err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_state", dbg_state, 2'd0);
    chk("idle_dig",   dig_en, 2'b00);

    // 4+4 = 8: ones shows 8, tens blank
    load(4'd4, 4'd4);
    chk("s8_sum",   sum_bin, 5'd8);
    chk("s8_valid", sum_valid, 1);
    chk("s8_err",   err, 0);
    chk("s8_ready", in_ready, 1);
    scan("s8", 7'b1111111, 7'b0000000, 5);

    // Reset mid-SHOW: outputs go dark in the same cycle
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_dig",   dig_en, 2'b00);
    chk("mrst_seg",   seg, 0);
    chk("mrst_valid", sum_valid, 0);
    chk("mrst_err",   err, 0);
    chk("mrst_sum",   sum_bin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mrst_ready", in_ready, 1);
    chk("mrst_state", dbg_state, 2'd0);
    chk("mrst_dark",  dig_en, 2'b00);

    // 9+9 = 18
    load(4'd9, 4'd9);
    chk("s18_sum",   sum_bin, 5'd18);
    chk("s18_valid", sum_valid, 1);
    scan("s18", 7'b1111111, 7'b0110000, 3);

    // Invalid operand: F+2 -> raw sum 17, error glyph
    load(4'hF, 4'd2);
    chk("e_sum",   sum_bin, 5'd17);
    chk("e_err",   err, 1);
    chk("e_valid", sum_valid, 0);
    scan("e", 7'b1001111, 7'b0000000, 2);

    // 6+7 = 13 clears the error
    load(4'd6, 4'd7);
    chk("s13_sum",   sum_bin, 5'd13);
    chk("s13_err",   err, 0);
    chk("s13_valid", sum_valid, 1);
    scan("s13", 7'b1111001, 7'b0110000, 2);

    // in_valid held high: 1+0 then 7+0, alternating ADD/SHOW
    op_a = 4'd1;
    op_b = 4'd0;
    in_valid = 1'b1;
    tick();
    chk("hv_add1_ready", in_ready, 0);
    chk("hv_add1_dig",   dig_en, 2'b00);
    op_a = 4'd7;
    tick();
    chk("hv_show1_ready", in_ready, 1);
    chk("hv_show1_sum",   sum_bin, 5'd1);
    chk("hv_show1_dig",   dig_en, 2'b01);
    chk("hv_show1_seg",   seg, 7'b0110000);
    tick();
    chk("hv_add2_ready", in_ready, 0);
    chk("hv_add2_dig",   dig_en, 2'b00);
    chk("hv_add2_seg",   seg, 0);
    in_valid = 1'b0;
    tick();
    chk("hv_show2_ready", in_ready, 1);
    chk("hv_show2_sum",   sum_bin, 5'd7);
    scan("s7", 7'b1110000, 7'b0000000, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
